// File: rtl/liu_pkg.sv
// Constants and types shared by the LIU control serializer and the LOS deserializer.
package liu_pkg;

  localparam int LIU_SLOTS  = 22;
  localparam int LIU_NCH    = 21;
  localparam int LIU_CK_DIV = 19;

  typedef logic [2*LIU_NCH-1:0] liu_ctrl_t;
  typedef logic [4:0]           liu_slot_t;
  typedef logic [5:0]           liu_div_t;

endpackage

// File: rtl/liu_bitclk_gen.sv
// Serial bit clock and slot sequencer for the LIU control lanes.
// bnd marks the Ck edge that starts a new bit; slot is the slot entered on that edge.
module liu_bitclk_gen
  import liu_pkg::*;
#(
  parameter int CK_DIV = LIU_CK_DIV,
  parameter int SLOTS  = LIU_SLOTS
) (
  input  logic      clk,
  input  logic      rst,
  output logic      ser_ck,
  output logic      bnd,
  output liu_slot_t slot
);

  liu_div_t  div_cnt;
  liu_div_t  div_nxt;
  liu_slot_t slot_cnt;

  always_comb begin
    bnd     = (div_cnt == liu_div_t'(CK_DIV - 1));
    div_nxt = bnd ? '0 : div_cnt + 1'b1;
    slot    = (slot_cnt == liu_slot_t'(SLOTS - 1)) ? '0 : slot_cnt + 1'b1;
  end

  // Reset parks both counters at their last value so the first live edge enters slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= liu_div_t'(CK_DIV - 1);
      slot_cnt <= liu_slot_t'(SLOTS - 1);
      ser_ck   <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      ser_ck  <= (div_nxt < liu_div_t'(CK_DIV / 2));
      if (bnd) begin
        slot_cnt <= slot;
      end
    end
  end

endmodule

// File: rtl/liu_ctrl_ser.sv
// Serializes the 42-bit per-E1 control vector onto two lockstep LIU control lanes.
// Define LIU_CTRL_PARITY_EN to carry per-lane even parity in slot NCH.
module liu_ctrl_ser
  import liu_pkg::*;
#(
  parameter int CK_DIV = LIU_CK_DIV,
  parameter int SLOTS  = LIU_SLOTS,
  parameter int NCH    = LIU_NCH
) (
  input  logic              Ck,
  input  logic              Rs,
  input  logic [2*NCH-1:0]  TX_E1_CTRL,
  output logic              LIU0_Ck,
  output logic              LIU0_DAT,
  output logic              LIU0_SYNC,
  output logic              LIU1_Ck,
  output logic              LIU1_DAT,
  output logic              LIU1_SYNC,
  output logic              FRM_STB
);

  logic             ser_ck;
  logic             bnd;
  liu_slot_t        slot;
  logic [2*NCH-1:0] shadow;
  logic [NCH-1:0]   lane0;
  logic [NCH-1:0]   lane1;
  logic             dat0;
  logic             dat1;
  logic             sync;
  logic             frm_stb;

  liu_bitclk_gen #(
    .CK_DIV (CK_DIV),
    .SLOTS  (SLOTS)
  ) u_bitclk (
    .clk    (Ck),
    .rst    (Rs),
    .ser_ck (ser_ck),
    .bnd    (bnd),
    .slot   (slot)
  );

  assign lane0 = shadow[NCH-1:0];
  assign lane1 = shadow[2*NCH-1:NCH];

  // Slot 0 bits come straight from the input so they match the shadow being loaded.
  always_ff @(posedge Ck) begin
    if (Rs) begin
      shadow  <= '0;
      dat0    <= 1'b0;
      dat1    <= 1'b0;
      sync    <= 1'b0;
      frm_stb <= 1'b0;
    end else begin
      frm_stb <= 1'b0;
      if (bnd) begin
        if (slot == '0) begin
          shadow  <= TX_E1_CTRL;
          dat0    <= TX_E1_CTRL[0];
          dat1    <= TX_E1_CTRL[NCH];
          sync    <= 1'b1;
          frm_stb <= 1'b1;
        end else if (slot < liu_slot_t'(NCH)) begin
          dat0 <= lane0[slot];
          dat1 <= lane1[slot];
          sync <= 1'b0;
        end else begin
          sync <= 1'b0;
`ifdef LIU_CTRL_PARITY_EN
          if (slot == liu_slot_t'(NCH)) begin
            dat0 <= ^lane0;
            dat1 <= ^lane1;
          end else begin
            dat0 <= 1'b0;
            dat1 <= 1'b0;
          end
`else
          dat0 <= 1'b0;
          dat1 <= 1'b0;
`endif
        end
      end
    end
  end

  assign LIU0_Ck   = ser_ck;
  assign LIU1_Ck   = ser_ck;
  assign LIU0_DAT  = dat0;
  assign LIU1_DAT  = dat1;
  assign LIU0_SYNC = sync;
  assign LIU1_SYNC = sync;
  assign FRM_STB   = frm_stb;

endmodule

// File: doc/liu_ctrl_ser.md
Name: liu_ctrl_ser

Overview:
- Transmit-side counterpart of the LIU LOS deserializer.
- Takes a 42-bit per-channel control vector (channels 0-20 to LIU0, 21-41 to LIU1) in the 38.88 MHz Ck domain.
- Emits two serial lanes, each with a generated ~2.048 MHz bit clock, a data bit and a channel-0 sync flag, in 22-slot frames.
- Sits between the per-E1 control registers and the two LIU devices' serial control inputs.

Parameters:
- CK_DIV, 19, Ck cycles per serial bit; 38.88/19 ≈ 2.046 MHz. Legal range 4..63.
- SLOTS, 22, slots per frame; slots 0..NCH-1 carry channels, the rest are spare.
- NCH, 21, channels per lane; must be less than SLOTS.

Ports:
- Ck  in  1  38.88 MHz system clock; the only clock.
- Rs  in  1  reset, synchronous, active-high.
- TX_E1_CTRL  in  2*NCH (42)  per-channel control bits; bit n is channel n.
- LIU0_Ck  out  1  lane-0 serial clock.
- LIU0_DAT  out  1  lane-0 serial data; slot k = channel k.
- LIU0_SYNC  out  1  high for the whole of slot 0.
- LIU1_Ck  out  1  lane-1 serial clock; identical to LIU0_Ck.
- LIU1_DAT  out  1  lane-1 serial data; slot k = channel NCH+k.
- LIU1_SYNC  out  1  high for the whole of slot 0; identical to LIU0_SYNC.
- FRM_STB  out  1  one-Ck pulse on the cycle TX_E1_CTRL is latched.

Behaviour:
- Reset (Rs high at a Ck edge):
  - div_cnt <= CK_DIV-1, slot_cnt <= SLOTS-1, shadow <= 0.
  - All outputs (Ck, DAT, SYNC, FRM_STB) are 0.
  - Reset asserted mid-frame aborts the frame at that edge, with no partial-slot completion.
- Divider:
  - div_cnt counts 0..CK_DIV-1 and wraps to 0.
  - Wrap to 0 = bit boundary (bnd).
  - LIUx_Ck is registered, high while div_cnt < CK_DIV/2 (floor).
  - Default: 9 cycles high, 10 low, period 19.
- Slot counter: advances on each bnd; wraps SLOTS-1 -> 0.
  - Frame = SLOTS*CK_DIV = 418 Ck cycles.
- Launch timing:
  - On the bnd edge, LIUx_Ck rises and DAT/SYNC update on the same edge, all registered.
  - Data are stable for the whole bit and are sampled by the LIU on the falling edge, mid-bit.
- Shadow load:
  - On the bnd edge that enters slot 0: shadow <= TX_E1_CTRL and FRM_STB = 1 for that cycle.
  - Slot 0 data are taken directly from TX_E1_CTRL[0] and [NCH], consistent with the shadow.
  - TX_E1_CTRL changes mid-frame have no effect until the next slot 0.
- First frame after reset:
  - The first Ck edge with Rs low is a bnd entering slot 0.
  - Outputs go Ck=1, SYNC=1, DAT=ch0 one cycle after Rs deasserts.
- Slots:
  - Slots k < NCH: LIU0_DAT = shadow[k], LIU1_DAT = shadow[NCH+k].
  - Slots >= NCH (slot 21): DAT = 0, unless the parity option is enabled.
- SYNC is 1 only in slot 0.
- Both lanes are always in lockstep; there is no per-lane skew.

Optional Feature:
- Macro: LIU_CTRL_PARITY_EN.
- Defined: slot NCH (slot 21) carries even parity of that lane's channel bits.
  - LIU0_DAT = ^shadow[NCH-1:0]; LIU1_DAT = ^shadow[2*NCH-1:NCH].
  - Any further spare slots stay 0.
- Undefined: all spare slots are driven 0; no parity logic is synthesised.

Decomposition:
- Shared package liu_pkg holds:
  - LIU_SLOTS=22, LIU_NCH=21, LIU_CK_DIV=19.
  - Typedef liu_ctrl_t (logic [41:0]) and slot-index typedef (logic [4:0]).
  - The deserializer uses the same constants.
- One natural sub-module, liu_bitclk_gen: owns div_cnt and slot_cnt, outputs ser_ck, bnd, slot.
- The top holds the shadow register, the per-lane data mux and the parity logic.

Test Plan:
- Reset: hold Rs for 5 cycles -> all outputs 0. Release -> next cycle Ck=1, SYNC=1, FRM_STB=1; Ck high 9, low 10, period 19 thereafter.
- Mapping: TX_E1_CTRL[20:0]=21'h000001, [41:21]=21'h100000 -> LIU0_DAT high only in slot 0, LIU1_DAT high only in slot 20; SYNC period 418 Ck.
- Coherence: change TX_E1_CTRL from 0 to all-ones during slot 10 -> current frame stays all-0; next frame all-1 in slots 0-20, slot 21 = 0 (parity off).
- Parity on: [20:0]=21'h000007, [41:21]=21'h000003 -> slot 21: LIU0_DAT=1, LIU1_DAT=0. Parity off: both 0.
- Mid-frame reset: assert Rs in slot 13 for 1 cycle -> outputs 0 next edge; release -> frame restarts at slot 0 with FRM_STB.
- Loopback: connect to the LIU LOS deserializer with random 42-bit vectors -> deserializer output equals the input vector within 2 frames (≤836 Ck).
